// File: rtl/frame_sync_ctrl.sv
// Per-channel frame-sync sequencer for the deserializer frame detector (80 MHz domain).
// Resets and enables the detector, hunts for clean framing, locks, and resyncs on error bursts.
module frame_sync_ctrl #(
   parameter int unsigned RST_CYCLES    = 4,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned LOCK_CNT      = 16,
   parameter int unsigned HUNT_TIMEOUT  = 256,
   parameter int unsigned WINDOW        = 64,
   parameter int unsigned ERR_LIMIT     = 3
) (
   input  logic        clk80,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        clr_counters,
   input  logic [4:0]  det_pdata,
   input  logic        det_error,
   output logic        det_reset,
   output logic        det_enable,
   output logic        locked,
   output logic [4:0]  dout,
   output logic        dout_valid,
   output logic [15:0] err_count,
   output logic [7:0]  resync_count,
   output logic [2:0]  state
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RST    = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_HUNT   = 3'd3;
   localparam logic [2:0] S_LOCKED = 3'd4;

   localparam int unsigned MAX_A   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int unsigned MAX_B   = (HUNT_TIMEOUT > WINDOW) ? HUNT_TIMEOUT : WINDOW;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned GOOD_W  = $clog2(LOCK_CNT + 1);
   localparam int unsigned WERR_W  = $clog2(ERR_LIMIT + 1);

   // cnt is the phase counter: RST/SETTLE length, HUNT elapsed time, LOCKED window position
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [GOOD_W-1:0] good, good_nxt;
   logic [WERR_W-1:0] werr, werr_nxt;
   logic [2:0]        state_nxt;
   logic              resync;
   logic              det_reset_nxt, det_enable_nxt, locked_nxt, dout_valid_nxt;
   logic [15:0]       err_count_nxt;
   logic [7:0]        resync_count_nxt;

   // next-state, counter and output decode
   always_comb begin
      state_nxt        = state;
      cnt_nxt          = cnt;
      good_nxt         = good;
      werr_nxt         = werr;
      resync           = 1'b0;
      err_count_nxt    = err_count;
      resync_count_nxt = resync_count;

      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RST;
         end
         S_RST: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(RST_CYCLES - 1)) state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_nxt = S_HUNT;
         end
         S_HUNT: begin
            cnt_nxt  = cnt + CNT_W'(1);
            good_nxt = det_error ? '0 : good + GOOD_W'(1);
            if (!det_error && (good == GOOD_W'(LOCK_CNT - 1))) begin
               state_nxt = S_LOCKED;
            end else if (cnt == CNT_W'(HUNT_TIMEOUT - 1)) begin
               state_nxt = S_RST;
               resync    = 1'b1;
            end
         end
         S_LOCKED: begin
            if (cnt == CNT_W'(WINDOW - 1)) begin
               cnt_nxt  = '0;
               werr_nxt = WERR_W'(det_error);
            end else begin
               cnt_nxt  = cnt + CNT_W'(1);
               werr_nxt = werr + WERR_W'(det_error);
            end
            if (werr_nxt == WERR_W'(ERR_LIMIT)) begin
               state_nxt = S_RST;
               resync    = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      if (stop) begin
         state_nxt = S_IDLE;
         resync    = 1'b0;
      end

      // every state is entered with fresh counters
      if (state_nxt != state) begin
         cnt_nxt  = '0;
         good_nxt = '0;
         werr_nxt = '0;
      end

      if (clr_counters) begin
         err_count_nxt = '0;
      end else if (det_error && ((state == S_HUNT) || (state == S_LOCKED)) &&
                   (err_count != 16'hFFFF)) begin
         err_count_nxt = err_count + 16'd1;
      end

      if (clr_counters) begin
         resync_count_nxt = '0;
      end else if (resync && (resync_count != 8'hFF)) begin
         resync_count_nxt = resync_count + 8'd1;
      end

      det_reset_nxt  = (state_nxt == S_RST);
      det_enable_nxt = (state_nxt == S_SETTLE) || (state_nxt == S_HUNT) || (state_nxt == S_LOCKED);
      locked_nxt     = (state_nxt == S_LOCKED);
      dout_valid_nxt = (state == S_LOCKED) && !det_error && (state_nxt == S_LOCKED);
   end

   always_ff @(posedge clk80 or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         good         <= '0;
         werr         <= '0;
         det_reset    <= 1'b0;
         det_enable   <= 1'b0;
         locked       <= 1'b0;
         dout         <= '0;
         dout_valid   <= 1'b0;
         err_count    <= '0;
         resync_count <= '0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         good         <= good_nxt;
         werr         <= werr_nxt;
         det_reset    <= det_reset_nxt;
         det_enable   <= det_enable_nxt;
         locked       <= locked_nxt;
         dout         <= det_pdata;
         dout_valid   <= dout_valid_nxt;
         err_count    <= err_count_nxt;
         resync_count <= resync_count_nxt;
      end
   end

endmodule

// File: doc/frame_sync_ctrl.md
Name: frame_sync_ctrl

Overview:
- Per-channel sequencer for a 400 MHz deserializer frame detector, running in the 80 MHz domain.
- Drives the detector's reset and enable, then hunts for stable framing by watching its error flag.
- Declares lock, forwards valid 5-bit words while locked, and forces a resync on excessive framing errors.
- Exposes error and resync statistics to the readout and control logic.

Parameters:
RST_CYCLES, 4, cycles det_reset is held high in RST (>=1)
SETTLE_CYCLES, 8, cycles after enable during which det_error is ignored (>=1)
LOCK_CNT, 16, consecutive error-free cycles in HUNT needed to lock (>=1)
HUNT_TIMEOUT, 256, max cycles in HUNT before forced resync (>LOCK_CNT)
WINDOW, 64, length in cycles of the LOCKED error-rate window (>=2)
ERR_LIMIT, 3, errors within one window that force a resync (1..WINDOW)

Ports:
clk80  in  1  80 MHz system clock
reset  in  1  asynchronous, active-high reset
start  in  1  request to begin synchronisation (pulse or level)
stop  in  1  return to IDLE; has priority over start
clr_counters  in  1  synchronous clear of err_count and resync_count
det_pdata  in  5  parallel word from the frame detector
det_error  in  1  framing-error flag from the frame detector
det_reset  out  1  reset to the frame detector
det_enable  out  1  enable to the frame detector
locked  out  1  high while in LOCKED
dout  out  5  forwarded data word
dout_valid  out  1  dout qualifier
err_count  out  16  saturating count of det_error cycles in HUNT/LOCKED
resync_count  out  8  saturating count of forced resyncs
state  out  3  FSM state code: IDLE=0, RST=1, SETTLE=2, HUNT=3, LOCKED=4

Behaviour:
- All outputs registered.
- On reset: state=IDLE; all outputs 0; all internal counters 0. Reset may assert at any time and takes effect immediately (asynchronous).
- IDLE: det_reset=0, det_enable=0. start=1 and stop=0 -> RST on the next cycle.
- RST: det_reset=1, det_enable=0 for exactly RST_CYCLES cycles, then -> SETTLE.
- SETTLE: det_reset=0, det_enable=1 for SETTLE_CYCLES cycles. det_error is not counted. Then -> HUNT.
- HUNT: det_enable=1.
  - good counter increments on each det_error=0 cycle and clears to 0 on each det_error=1 cycle.
  - When good counter would reach LOCK_CNT -> LOCKED; first LOCKED cycle follows the LOCK_CNT-th clean cycle.
  - Elapsed-cycle counter reaching HUNT_TIMEOUT without lock -> RST and resync_count++.
  - If lock and timeout fall on the same cycle, lock wins.
- LOCKED: locked=1, det_enable=1.
  - Window counter runs 0..WINDOW-1 and wraps. On the wrap cycle the window error count resets to 0, or to 1 if det_error=1 on that cycle.
  - Each det_error=1 cycle increments the window error count.
  - When the window error count reaches ERR_LIMIT -> RST on the next cycle, resync_count++, locked drops together with the state change.
  - On LOCKED entry, window counter and window error count start at 0.
- Data path:
  - dout <= det_pdata every cycle.
  - dout_valid <= (state==LOCKED) && !det_error, one cycle latency.
  - dout_valid=0 in all other states; dout holds its last value when not valid.
- stop=1 in any state -> IDLE next cycle; det_reset, det_enable, locked and dout_valid go 0 with the state change. start while not in IDLE is ignored.
- err_count: +1 per det_error=1 cycle in HUNT or LOCKED, saturating at 16'hFFFF.
- resync_count: +1 per forced resync (HUNT timeout or LOCKED error limit), saturating at 8'hFF. stop does not count as a resync.
- clr_counters=1: both counters go to 0 that cycle; clear wins over a simultaneous increment. FSM is unaffected.
- Counter widths: derived from the parameters with clog2; no wrap-around except the LOCKED window counter.

Test Plan:
- Reset, then start pulse with det_error=0 -> state trace 1 (4 cycles), 2 (8 cycles), 3 (16 cycles), then 4. locked=1 and dout_valid=1 from the next cycle; dout tracks det_pdata=5'h15 with 1-cycle delay.
- In HUNT, assert det_error once after 10 clean cycles -> good counter restarts; lock occurs 16 clean cycles later; err_count=1.
- In LOCKED, 3 det_error pulses within 64 cycles -> RST; resync_count=1; locked and dout_valid drop; full sequence repeats to lock.
- In LOCKED, 2 errors, then window wrap, then 2 errors -> stays LOCKED; error on the wrap cycle counts into the new window.
- det_error held 1 through HUNT -> timeout after 256 cycles into RST. Repeated 300 times -> resync_count saturates at 255; err_count saturates at 65535 with clr_counters idle.
- stop and start together in LOCKED -> IDLE with all outputs 0. clr_counters coinciding with an error -> err_count=0. Async reset mid-RST -> immediate IDLE, det_reset=0.
